candle_led_driver: RTL and testbench



---
 rtl/candle_led_driver_if.sv | 28 ++
 rtl/candle_led_driver.sv | 141 ++++++++++++++
 tb/tb_candle_led_driver.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/candle_led_driver_if.sv
// Candle LED driver bus: lit requests and enable in, LED drive and status out.
interface candle_led_driver_if #(
    parameter int unsigned NUM_CANDLES = 8
);
    localparam int unsigned CNT_W = $clog2(NUM_CANDLES + 1);

    logic [NUM_CANDLES-1:0] candle_state;
    logic                   enable;
    logic [NUM_CANDLES-1:0] led;
    logic                   busy;
    logic [CNT_W-1:0]       lit_count;

    modport master (
        output candle_state,
        output enable,
        input  led,
        input  busy,
        input  lit_count
    );

    modport slave (
        input  candle_state,
        input  enable,
        output led,
        output busy,
        output lit_count
    );
endinterface

// File: rtl/candle_led_driver.sv
// Candle LED driver: per-candle fade-in/fade-out FSM with LFSR flicker and PWM output.
// Flicker taps the low PWM_BITS of a rotated 16-bit LFSR, so PWM_BITS must be <= 16.
module candle_led_driver #(
    parameter int unsigned NUM_CANDLES   = 8,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned TICK_DIV      = 100000,
    parameter int unsigned FADE_STEP     = 4,
    parameter int unsigned FLICKER_DEPTH = 64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic           sys_clk,
    input logic           rst,
    candle_led_driver_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(NUM_CANDLES + 1);
    localparam int unsigned PW    = $clog2(TICK_DIV);
    localparam logic [PWM_BITS-1:0] FULL       = '1;
    localparam logic [PWM_BITS:0]   STEP       = (PWM_BITS + 1)'(FADE_STEP);
    localparam logic [PWM_BITS-1:0] FLICK_MASK = PWM_BITS'(FLICKER_DEPTH - 1);
    localparam logic [PW-1:0]       PRESC_MAX  = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StOff, StFadeIn, StLit, StFadeOut} state_e;

    state_e              state_q   [NUM_CANDLES];
    logic [PWM_BITS-1:0] level_q   [NUM_CANDLES];
    logic [PWM_BITS-1:0] flick_q   [NUM_CANDLES];
    logic [PWM_BITS-1:0] flick_new [NUM_CANDLES];
    logic [PWM_BITS-1:0] up_lvl    [NUM_CANDLES];
    logic [PWM_BITS-1:0] dn_lvl    [NUM_CANDLES];
    logic [PWM_BITS-1:0] duty      [NUM_CANDLES];
    logic [PWM_BITS:0]   sum_w     [NUM_CANDLES];
    logic [PWM_BITS:0]   diff_w    [NUM_CANDLES];

    logic [PW-1:0]          presc_q;
    logic [PWM_BITS-1:0]    pwm_q;
    logic [15:0]            lfsr_q;
    logic [15:0]            lfsr_next;
    logic                   tick;
    logic [NUM_CANDLES-1:0] led_q, led_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       lit_count_q, lit_count_d;

    assign tick      = bus.enable && (presc_q == PRESC_MAX);
    // Galois step for x^16+x^14+x^13+x^11, shifting right.
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Saturating fade arithmetic, duty selection and per-candle flicker taps.
    always_comb begin
        for (int i = 0; i < NUM_CANDLES; i++) begin
            sum_w[i]     = {1'b0, level_q[i]} + STEP;
            diff_w[i]    = {1'b0, level_q[i]} - STEP;
            up_lvl[i]    = sum_w[i][PWM_BITS] ? FULL : sum_w[i][PWM_BITS-1:0];
            dn_lvl[i]    = diff_w[i][PWM_BITS] ? '0 : diff_w[i][PWM_BITS-1:0];
            duty[i]      = (state_q[i] == StLit) ? (FULL - flick_q[i]) : level_q[i];
            flick_new[i] = PWM_BITS'({lfsr_q, lfsr_q} >> ((2 * i) % 16)) & FLICK_MASK;
        end
    end

    // Next values for LED drive and status outputs.
    always_comb begin
        led_d       = '0;
        busy_d      = 1'b0;
        lit_count_d = '0;
        for (int i = 0; i < NUM_CANDLES; i++) begin
            led_d[i] = bus.enable && ((duty[i] == FULL) || (pwm_q < duty[i]));
            if (state_q[i] == StFadeIn || state_q[i] == StFadeOut) busy_d = 1'b1;
            if (state_q[i] == StLit) lit_count_d = lit_count_d + CNT_W'(1);
        end
    end

    // Timebase: prescaler, PWM counter, LFSR and latched flicker; all frozen when disabled.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            presc_q <= '0;
            pwm_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            for (int i = 0; i < NUM_CANDLES; i++) flick_q[i] <= '0;
        end else if (bus.enable) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            pwm_q   <= pwm_q + PWM_BITS'(1);
            if (tick) begin
                lfsr_q <= lfsr_next;
                for (int i = 0; i < NUM_CANDLES; i++) flick_q[i] <= flick_new[i];
            end
        end
    end

    // Per-candle fade FSM; requests are only looked at on tick cycles.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CANDLES; i++) begin
                state_q[i] <= StOff;
                level_q[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NUM_CANDLES; i++) begin
                unique case (state_q[i])
                    StOff: begin
                        if (bus.candle_state[i]) state_q[i] <= StFadeIn;
                    end
                    StFadeIn: begin
                        if (!bus.candle_state[i]) begin
                            state_q[i] <= StFadeOut;
                        end else begin
                            level_q[i] <= up_lvl[i];
                            if (up_lvl[i] == FULL) state_q[i] <= StLit;
                        end
                    end
                    StLit: begin
                        if (!bus.candle_state[i]) state_q[i] <= StFadeOut;
                    end
                    StFadeOut: begin
                        if (bus.candle_state[i]) begin
                            state_q[i] <= StFadeIn;
                        end else begin
                            level_q[i] <= dn_lvl[i];
                            if (dn_lvl[i] == '0) state_q[i] <= StOff;
                        end
                    end
                endcase
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            led_q       <= '0;
            busy_q      <= 1'b0;
            lit_count_q <= '0;
        end else begin
            led_q       <= led_d;
            busy_q      <= busy_d;
            lit_count_q <= lit_count_d;
        end
    end

    assign bus.led       = led_q;
    assign bus.busy      = busy_q;
    assign bus.lit_count = lit_count_q;
endmodule

// File: tb/tb_candle_led_driver.sv
// Bench for candle_led_driver: two instances (fast no-flicker, PWM-aligned flicker)
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_candle_led_driver;
    localparam int N    = 8;
    localparam int OFF  = 0;
    localparam int FIN  = 1;
    localparam int LIT  = 2;
    localparam int FOUT = 3;
    localparam int STEP = 64;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic [7:0] cs;
    logic       en;

    always #5 sys_clk = ~sys_clk;

    candle_led_driver_if #(.NUM_CANDLES(N)) bus_a ();
    candle_led_driver_if #(.NUM_CANDLES(N)) bus_b ();

    assign bus_a.candle_state = cs;
    assign bus_a.enable       = en;
    assign bus_b.candle_state = cs;
    assign bus_b.enable       = en;

    candle_led_driver #(
        .NUM_CANDLES(N), .PWM_BITS(8), .TICK_DIV(4), .FADE_STEP(STEP),
        .FLICKER_DEPTH(1), .LFSR_SEED(16'hACE1)
    ) dut_a (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus_a)
    );

    candle_led_driver #(
        .NUM_CANDLES(N), .PWM_BITS(8), .TICK_DIV(256), .FADE_STEP(STEP),
        .FLICKER_DEPTH(64), .LFSR_SEED(16'hACE1)
    ) dut_b (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus_b)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------------
    int          m_presc [2];
    int          m_pwm   [2];
    int          m_st    [2][N];
    int          m_lvl   [2][N];
    int          m_flk   [2][N];
    logic [15:0] m_lfsr  [2];
    logic [7:0]  m_led   [2];
    int          m_busy  [2];
    int          m_litc  [2];
    bit          m_tick  [2];
    bit          m_valid = 1'b0;

    function automatic int tick_div(input int k);
        return (k == 0) ? 4 : 256;
    endfunction

    function automatic int fdepth(input int k);
        return (k == 0) ? 1 : 64;
    endfunction

    task automatic model_step(input int k);
        int          duty;
        int          nb;
        int          lc;
        logic [31:0] dbl;
        logic        lsb;
        if (rst) begin
            m_presc[k] = 0;
            m_pwm[k]   = 0;
            m_lfsr[k]  = 16'hACE1;
            m_led[k]   = 8'h00;
            m_busy[k]  = 0;
            m_litc[k]  = 0;
            m_tick[k]  = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_st[k][i]  = OFF;
                m_lvl[k][i] = 0;
                m_flk[k][i] = 0;
            end
            m_valid = 1'b1;
        end else begin
            nb = 0;
            lc = 0;
            for (int i = 0; i < N; i++) begin
                if (m_st[k][i] == FIN || m_st[k][i] == FOUT) nb = 1;
                if (m_st[k][i] == LIT) lc++;
            end
            m_busy[k] = nb;
            m_litc[k] = lc;
            if (!en) begin
                m_led[k]  = 8'h00;
                m_tick[k] = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    duty = (m_st[k][i] == LIT) ? 255 - m_flk[k][i] : m_lvl[k][i];
                    m_led[k][i] = (duty == 255) || (m_pwm[k] < duty);
                end
                m_tick[k]  = (m_presc[k] == tick_div(k) - 1);
                m_presc[k] = m_tick[k] ? 0 : m_presc[k] + 1;
                m_pwm[k]   = (m_pwm[k] + 1) % 256;
                if (m_tick[k]) begin
                    for (int i = 0; i < N; i++) begin
                        dbl = {m_lfsr[k], m_lfsr[k]} >> (2 * i);
                        m_flk[k][i] = int'(dbl[15:0]) & (fdepth(k) - 1);
                        case (m_st[k][i])
                            OFF: if (cs[i]) m_st[k][i] = FIN;
                            FIN: begin
                                if (!cs[i]) m_st[k][i] = FOUT;
                                else begin
                                    m_lvl[k][i] = (m_lvl[k][i] + STEP > 255) ? 255
                                                                             : m_lvl[k][i] + STEP;
                                    if (m_lvl[k][i] == 255) m_st[k][i] = LIT;
                                end
                            end
                            LIT: if (!cs[i]) m_st[k][i] = FOUT;
                            default: begin
                                if (cs[i]) m_st[k][i] = FIN;
                                else begin
                                    m_lvl[k][i] = (m_lvl[k][i] - STEP < 0) ? 0
                                                                           : m_lvl[k][i] - STEP;
                                    if (m_lvl[k][i] == 0) m_st[k][i] = OFF;
                                end
                            end
                        endcase
                    end
                    lsb       = m_lfsr[k][0];
                    m_lfsr[k] = m_lfsr[k] >> 1;
                    if (lsb) m_lfsr[k] = m_lfsr[k] ^ 16'hB400;
                end
            end
        end
    endtask

    always @(posedge sys_clk) begin
        model_step(0);
        model_step(1);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge sys_clk) begin
        if (m_valid) begin
            chk("model_led_a",  bus_a.led,       m_led[0]);
            chk("model_busy_a", bus_a.busy,      m_busy[0]);
            chk("model_lit_a",  bus_a.lit_count, m_litc[0]);
            chk("model_led_b",  bus_b.led,       m_led[1]);
            chk("model_busy_b", bus_b.busy,      m_busy[1]);
            chk("model_lit_b",  bus_b.lit_count, m_litc[1]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_tick(input int k);
        bit got = 1'b0;
        for (int c = 0; c < 600 && !got; c++) begin
            @(negedge sys_clk);
            if (m_tick[k]) got = 1'b1;
        end
        if (!got) chk("tick_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    int  exp_lv [5] = '{0, 64, 128, 192, 255};
    int  win    [12][N];
    int  hi     [N];
    int  expw   [N];
    bit  all_lit;
    bit  found;
    bit  differ;

    initial begin
        rst = 1'b1;
        cs  = 8'hFF;
        en  = 1'b1;

        // Reset held with every request active.
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            chk("rst_led_a",  bus_a.led,       0);
            chk("rst_busy_a", bus_a.busy,      0);
            chk("rst_lit_a",  bus_a.lit_count, 0);
            chk("rst_led_b",  bus_b.led,       0);
        end
        rst = 1'b0;
        wait_tick(0);
        chk("first_tick_fadein", m_st[0][0], FIN);
        cyc(1);
        chk("first_tick_busy", bus_a.busy, 1);

        // Ignition fade on candle 0.
        pulse_reset();
        cs = 8'h01;
        for (int t = 0; t < 5; t++) begin
            wait_tick(0);
            chk($sformatf("fade_lvl_%0d", t), m_lvl[0][0], exp_lv[t]);
            if (t == 0) begin
                cyc(1);
                chk("fade_busy", bus_a.busy, 1);
            end
        end
        chk("fade_lit_state", m_st[0][0], LIT);
        cyc(1);
        chk("fade_busy_done", bus_a.busy, 0);
        chk("fade_lit_count", bus_a.lit_count, 1);
        cyc(1);
        for (int c = 0; c < 16; c++) begin
            chk("lit_led_const", bus_a.led, 8'h01);
            cyc(1);
        end

        // Reverse mid-fade at level 128.
        pulse_reset();
        cs = 8'h01;
        repeat (3) wait_tick(0);
        chk("rev_start_lvl", m_lvl[0][0], 128);
        cs = 8'h00;
        wait_tick(0);
        chk("rev_fadeout_lvl", m_lvl[0][0], 128);
        chk("rev_fadeout_st", m_st[0][0], FOUT);
        wait_tick(0);
        chk("rev_lvl_64", m_lvl[0][0], 64);
        wait_tick(0);
        chk("rev_lvl_0", m_lvl[0][0], 0);
        chk("rev_off_st", m_st[0][0], OFF);
        cyc(2);
        chk("rev_busy_low", bus_a.busy, 0);
        for (int c = 0; c < 20; c++) begin
            chk("rev_led_off", bus_a.led, 8'h00);
            cyc(1);
        end

        // Enable freeze during FADE_IN at level 128.
        pulse_reset();
        cs = 8'h01;
        repeat (3) wait_tick(0);
        en = 1'b0;
        cyc(1);
        for (int c = 0; c < 80; c++) begin
            chk("freeze_led_a", bus_a.led, 8'h00);
            chk("freeze_led_b", bus_b.led, 8'h00);
            cyc(1);
        end
        chk("freeze_lvl_hold", m_lvl[0][0], 128);
        en = 1'b1;
        wait_tick(0);
        chk("resume_lvl_192", m_lvl[0][0], 192);

        // Reset mid-operation: candles 0..3 lit, 4..7 fading in.
        pulse_reset();
        cs = 8'h0F;
        repeat (5) wait_tick(0);
        cs = 8'hFF;
        repeat (2) wait_tick(0);
        cyc(1);
        chk("mid_busy_pre", bus_a.busy, 1);
        chk("mid_lit_pre", bus_a.lit_count, 4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_rst_led_a",  bus_a.led,       0);
        chk("mid_rst_busy_a", bus_a.busy,      0);
        chk("mid_rst_lit_a",  bus_a.lit_count, 0);
        chk("mid_rst_led_b",  bus_b.led,       0);
        chk("mid_rst_lfsr",   m_lfsr[0],       16'hACE1);

        // Flicker on dut_b: tick period equals the PWM period.
        pulse_reset();
        cs = 8'hFF;
        all_lit = 1'b0;
        for (int c = 0; c < 3000 && !all_lit; c++) begin
            @(negedge sys_clk);
            all_lit = 1'b1;
            for (int i = 0; i < N; i++) if (m_st[1][i] != LIT) all_lit = 1'b0;
        end
        chk("flick_all_lit_timeout", all_lit, 1);
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            if (m_pwm[1] == 1) found = 1'b1;
            else @(negedge sys_clk);
        end
        chk("flick_align_timeout", found, 1);
        for (int w = 0; w < 12; w++) begin
            for (int i = 0; i < N; i++) begin
                hi[i]   = 0;
                // A zero dip gives duty FULL, which drives the LED constantly on.
                expw[i] = (m_flk[1][i] == 0) ? 256 : 255 - m_flk[1][i];
            end
            repeat (256) begin
                for (int i = 0; i < N; i++) hi[i] += int'(bus_b.led[i]);
                @(negedge sys_clk);
            end
            for (int i = 0; i < N; i++) begin
                win[w][i] = hi[i];
                chk($sformatf("flick_hi_w%0d_c%0d", w, i), hi[i], expw[i]);
                chk($sformatf("flick_range_w%0d_c%0d", w, i),
                    (hi[i] >= 192 && hi[i] <= 256) ? 1 : 0, 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            differ = 1'b0;
            for (int w = 1; w < 12; w++) if (win[w][i] != win[0][i]) differ = 1'b1;
            chk($sformatf("flick_varies_c%0d", i), differ, 1);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                differ = 1'b0;
                for (int w = 0; w < 12; w++) if (win[w][i] != win[w][j]) differ = 1'b1;
                chk($sformatf("flick_pair_%0d_%0d", i, j), differ, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d",
                 n_checks, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
